// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave front end of the command RAM wrapper:
//   - FSM state encoding
//   - frame command codes carried in frame bits [9:8]
//   - default frame / byte widths and read-wait timeout length
//   - helper that tracks whether a read address has been forwarded
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int RX_WIDTH_DEF       = 10;
    localparam int TX_WIDTH_DEF       = 8;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_t;

    // A read-address frame arms the next read; a read-data frame consumes it.
    function automatic logic next_rd_addr_seen(input logic [1:0] cmd, input logic cur);
        logic nxt;
        case (cmd)
            CMD_RD_ADDR: nxt = 1'b1;
            CMD_RD_DATA: nxt = 1'b0;
            default:     nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// -----------------------------------------------------------------------------
// spi_tx_shifter
// Parallel-load, MSB-first shift-out register driving MISO.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   clear       : synchronous clear of all state (frame ended)
//   load        : capture load_data; serial_out shows its MSB after this edge
//   load_data   : byte to send
//   serial_out  : registered serial bit, 0 when idle
//   done        : set once the last bit has been presented, held until
//                 the next load or clear
// -----------------------------------------------------------------------------
module spi_tx_shifter
#(
    parameter int WIDTH = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             serial_out,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             serial_r;
    logic             done_r;

    // Load / shift engine; the MSB goes out on the load edge itself so the
    // first serial bit appears without an extra cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r   <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            serial_r <= 1'b0;
            done_r   <= 1'b0;
        end else if (clear) begin
            data_r   <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            serial_r <= 1'b0;
            done_r   <= 1'b0;
        end else if (load) begin
            serial_r <= load_data[WIDTH-1];
            data_r   <= {load_data[WIDTH-2:0], 1'b0};
            cnt_r    <= CNT_W'(WIDTH - 1);
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
        end else if (busy_r) begin
            if (cnt_r != {CNT_W{1'b0}}) begin
                serial_r <= data_r[WIDTH-1];
                data_r   <= {data_r[WIDTH-2:0], 1'b0};
                cnt_r    <= cnt_r - CNT_W'(1);
            end else begin
                serial_r <= 1'b0;
                busy_r   <= 1'b0;
                done_r   <= 1'b1;
            end
        end else begin
            serial_r <= 1'b0;
        end
    end

    assign serial_out = serial_r;
    assign done       = done_r;

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI slave front end for the single-port command RAM. The SPI bit clock is
// the system clock; SS_n frames each transaction.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   SS_n, MOSI   : slave select (active low) and serial data in, MSB first
//   MISO         : serial read data out, MSB first, 0 when not sending
//   rx_data      : assembled 10-bit frame, valid with the rx_valid strobe
//   rx_valid     : one-cycle frame strobe to the RAM
//   tx_data      : read byte from the RAM
//   tx_valid     : read byte valid (level, may still be high from last read)
//   err_timeout  : sticky read-wait timeout flag
// Optional build macro SPI_SLAVE_TX_TIMEOUT_EN adds a watchdog on the wait for
// tx_valid; without it the slave waits indefinitely and err_timeout is 0.
// -----------------------------------------------------------------------------
module spi_slave
    import spi_pkg::*;
#(
    parameter int RX_WIDTH       = RX_WIDTH_DEF,
    parameter int TX_WIDTH       = TX_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic [RX_WIDTH-1:0] rx_data,
    output logic                rx_valid,
    input  logic [TX_WIDTH-1:0] tx_data,
    input  logic                tx_valid,
    output logic                err_timeout
);

    // The bit counter doubles as the frame phase once all bits are in:
    //   PH_LAST  all RX_WIDTH bits shifted, forward on this edge
    //   PH_VALID rx_valid cycle; tx_valid here may be stale and is ignored
    //   PH_WAIT  waiting for tx_valid (read-data only)
    //   PH_SHIFT byte going out on MISO
    //   PH_HOLD  nothing more to do until SS_n rises
    localparam int CNT_W = $clog2(RX_WIDTH + 5);
    localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(RX_WIDTH);
    localparam logic [CNT_W-1:0] PH_VALID = CNT_W'(RX_WIDTH + 1);
    localparam logic [CNT_W-1:0] PH_WAIT  = CNT_W'(RX_WIDTH + 2);
    localparam logic [CNT_W-1:0] PH_SHIFT = CNT_W'(RX_WIDTH + 3);
    localparam logic [CNT_W-1:0] PH_HOLD  = CNT_W'(RX_WIDTH + 4);

    spi_state_t          state_r;
    logic [CNT_W-1:0]    bit_cnt_r;
    logic [RX_WIDTH-1:0] shift_r;
    logic [RX_WIDTH-1:0] rx_data_r;
    logic                rx_valid_r;
    logic                rd_addr_seen_r;

    logic                tx_load_s;
    logic                tx_clear_s;
    logic                tx_miso_s;
    logic                tx_done_s;

`ifdef SPI_SLAVE_TX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]    tmo_cnt_r;
    logic                err_timeout_r;
`else
    // The timeout length only matters when the watchdog is built in.
    logic                unused_tmo_s;
    assign unused_tmo_s = ^TIMEOUT_CYCLES;
`endif

    // Decode when the MISO shifter captures the RAM byte or is flushed.
    always_comb begin
        tx_load_s  = 1'b0;
        tx_clear_s = 1'b0;
        if (SS_n) begin
            tx_clear_s = 1'b1;
        end else if ((state_r == READ_DATA) && (bit_cnt_r == PH_WAIT) && tx_valid) begin
            tx_load_s = 1'b1;
        end else begin
            tx_load_s  = 1'b0;
            tx_clear_s = 1'b0;
        end
    end

    // Frame FSM: command decode, deserialisation, forwarding and read wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            bit_cnt_r      <= {CNT_W{1'b0}};
            shift_r        <= {RX_WIDTH{1'b0}};
            rx_data_r      <= {RX_WIDTH{1'b0}};
            rx_valid_r     <= 1'b0;
            rd_addr_seen_r <= 1'b0;
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
            tmo_cnt_r      <= {TMO_W{1'b0}};
            err_timeout_r  <= 1'b0;
`endif
        end else begin
            rx_valid_r <= 1'b0;
            if (SS_n) begin
                // Frame aborted or finished: drop partial data, keep rd_addr_seen.
                state_r   <= IDLE;
                bit_cnt_r <= {CNT_W{1'b0}};
                shift_r   <= {RX_WIDTH{1'b0}};
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
                tmo_cnt_r <= {TMO_W{1'b0}};
`endif
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r   <= CHK_CMD;
                        bit_cnt_r <= {CNT_W{1'b0}};
                        shift_r   <= {RX_WIDTH{1'b0}};
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
                        tmo_cnt_r     <= {TMO_W{1'b0}};
                        err_timeout_r <= 1'b0;
`endif
                    end
                    CHK_CMD: begin
                        // First MOSI bit is frame bit 9 and picks the branch.
                        shift_r   <= {{(RX_WIDTH-1){1'b0}}, MOSI};
                        bit_cnt_r <= CNT_W'(1);
                        if (!MOSI) begin
                            state_r <= WRITE;
                        end else if (rd_addr_seen_r) begin
                            state_r <= READ_DATA;
                        end else begin
                            state_r <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (bit_cnt_r < PH_LAST) begin
                            shift_r   <= {shift_r[RX_WIDTH-2:0], MOSI};
                            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        end else if (bit_cnt_r == PH_LAST) begin
                            rx_data_r      <= shift_r;
                            rx_valid_r     <= 1'b1;
                            rd_addr_seen_r <= next_rd_addr_seen(shift_r[RX_WIDTH-1 -: 2],
                                                                rd_addr_seen_r);
                            bit_cnt_r      <= PH_VALID;
                        end else if (state_r == READ_DATA) begin
                            if (bit_cnt_r == PH_VALID) begin
                                bit_cnt_r <= PH_WAIT;
                            end else if (bit_cnt_r == PH_WAIT) begin
                                if (tx_valid) begin
                                    bit_cnt_r <= PH_SHIFT;
                                end else begin
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
                                    if (tmo_cnt_r == TMO_LAST) begin
                                        err_timeout_r <= 1'b1;
                                        bit_cnt_r     <= PH_HOLD;
                                    end else begin
                                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                                    end
`else
                                    bit_cnt_r <= PH_WAIT;
`endif
                                end
                            end else if ((bit_cnt_r == PH_SHIFT) && tx_done_s) begin
                                bit_cnt_r <= PH_HOLD;
                            end else begin
                                bit_cnt_r <= bit_cnt_r;
                            end
                        end else begin
                            // Write / read-address frames hold after forwarding.
                            bit_cnt_r <= bit_cnt_r;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        bit_cnt_r <= {CNT_W{1'b0}};
                        shift_r   <= {RX_WIDTH{1'b0}};
                    end
                endcase
            end
        end
    end

    spi_tx_shifter #(
        .WIDTH      (TX_WIDTH)
    ) u_tx_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (tx_clear_s),
        .load       (tx_load_s),
        .load_data  (tx_data),
        .serial_out (tx_miso_s),
        .done       (tx_done_s)
    );

    assign MISO     = tx_miso_s;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
    assign err_timeout = err_timeout_r;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Directed self-checking bench for spi_slave. Inputs change on the falling
// edge and outputs are observed on the falling edge, half a cycle after the
// rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       err_timeout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    spi_slave dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SS_n        (SS_n),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Drives one frame from IDLE: SS_n low for the CHK_CMD entry edge (E0),
    // bits 9..0 on E1..E10, then extra 1-bits. Returns after E12 is observed.
    task automatic do_frame(input logic [9:0] f, output int n_valid, output int first_edge,
                            output logic [9:0] got, output int miso_hi);
        n_valid = 0; first_edge = -1; got = 10'h000; miso_hi = 0;
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                n_valid++;
                if (first_edge < 0) first_edge = k - 1;
                got = rx_data;
            end
            if (MISO !== 1'b0) miso_hi++;
            MOSI = (k <= 10) ? f[10-k] : 1'b1;
        end
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int nv, fe, mh, cnt;
        logic [9:0] got;
        @(negedge clk);
        total_cnt++; if (MISO !== 1'b0) $display("FAIL reset_miso: got %b expected 0", MISO); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else pass_cnt++;
        total_cnt++; if (rx_data !== 10'h000) $display("FAIL reset_rx_data: got %h expected 000", rx_data); else pass_cnt++;
        total_cnt++; if (err_timeout !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_timeout); else pass_cnt++;
        rst_n = 1'b1;
        // Arm rd_addr_seen, then reset mid-frame: it must be forgotten.
        do_frame(10'h201, nv, fe, got, mh);
        total_cnt++; if (got !== 10'h201 || nv != 1) $display("FAIL pre_reset_frame: got %h x%0d expected 201 x1", got, nv); else pass_cnt++;
        end_frame();
        @(negedge clk);
        SS_n = 1'b0; MOSI = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (rx_data !== 10'h000) $display("FAIL midframe_rst_rx_data: got %h expected 000", rx_data); else pass_cnt++;
        total_cnt++; if (MISO !== 1'b0 || rx_valid !== 1'b0) $display("FAIL midframe_rst_out: got miso %b vld %b expected 0 0", MISO, rx_valid); else pass_cnt++;
        @(negedge clk);
        SS_n = 1'b1; rst_n = 1'b1;
        cnt = 0;
        repeat (13) begin @(negedge clk); if (rx_valid === 1'b1) cnt++; end
        total_cnt++; if (cnt != 0) $display("FAIL post_rst_no_valid: got %0d expected 0", cnt); else pass_cnt++;
        // 11-frame now goes to READ_ADD, so a ready RAM byte must not be sent.
        tx_data = 8'hFF; tx_valid = 1'b1;
        do_frame(10'h300, nv, fe, got, mh);
        total_cnt++; if (got !== 10'h300 || nv != 1 || fe != 11) $display("FAIL post_rst_frame: got %h x%0d @%0d expected 300 x1 @11", got, nv, fe); else pass_cnt++;
        cnt = mh;
        repeat (10) begin @(negedge clk); if (MISO !== 1'b0) cnt++; end
        total_cnt++; if (cnt != 0) $display("FAIL rd_addr_seen_cleared: got %0d MISO highs expected 0", cnt); else pass_cnt++;
        end_frame();
        tx_valid = 1'b0; tx_data = 8'h00;
    endtask

    task automatic test_write();
        int nv, fe, mh;
        logic [9:0] got;
        do_frame(10'h0A5, nv, fe, got, mh);
        total_cnt++; if (nv != 1) $display("FAIL write_valid_count: got %0d expected 1", nv); else pass_cnt++;
        total_cnt++; if (fe != 11) $display("FAIL write_latency: got %0d expected 11", fe); else pass_cnt++;
        total_cnt++; if (got !== 10'h0A5) $display("FAIL write_data: got %h expected 0a5", got); else pass_cnt++;
        total_cnt++; if (mh != 0) $display("FAIL write_miso: got %0d highs expected 0", mh); else pass_cnt++;
        end_frame();
    endtask

    task automatic test_read();
        int nv, fe, mh;
        logic [9:0] got;
        logic [8:0] exp_bits;
        do_frame(10'h207, nv, fe, got, mh);
        total_cnt++; if (got !== 10'h207 || nv != 1) $display("FAIL rd_addr_frame: got %h x%0d expected 207 x1", got, nv); else pass_cnt++;
        end_frame();
        do_frame(10'h300, nv, fe, got, mh);
        total_cnt++; if (got !== 10'h300 || nv != 1) $display("FAIL rd_data_frame: got %h x%0d expected 300 x1", got, nv); else pass_cnt++;
        total_cnt++; if (mh != 0) $display("FAIL rd_data_miso_early: got %0d highs expected 0", mh); else pass_cnt++;
        tx_data = 8'h3C; tx_valid = 1'b1;
        exp_bits = 9'b0_0111_1000;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            total_cnt++;
            if (MISO !== exp_bits[8-j]) $display("FAIL read_miso_bit%0d: got %b expected %b", j, MISO, exp_bits[8-j]);
            else pass_cnt++;
        end
        end_frame();
    endtask

    task automatic test_stale_tx_valid();
        int nv, fe, mh;
        logic [9:0] got;
        logic [8:0] exp_bits;
        tx_data = 8'hC3; tx_valid = 1'b1;
        do_frame(10'h2FF, nv, fe, got, mh);
        total_cnt++; if (got !== 10'h2FF || nv != 1) $display("FAIL stale_addr_frame: got %h x%0d expected 2ff x1", got, nv); else pass_cnt++;
        end_frame();
        do_frame(10'h300, nv, fe, got, mh);
        total_cnt++; if (mh != 0) $display("FAIL stale_not_captured: got %0d highs expected 0", mh); else pass_cnt++;
        tx_valid = 1'b0; tx_data = 8'h96;
        @(negedge clk);
        total_cnt++; if (MISO !== 1'b0) $display("FAIL stale_wait1: got %b expected 0", MISO); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (MISO !== 1'b0) $display("FAIL stale_wait2: got %b expected 0", MISO); else pass_cnt++;
        tx_valid = 1'b1;
        exp_bits = 9'b1_0010_1100;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            total_cnt++;
            if (MISO !== exp_bits[8-j]) $display("FAIL fresh_miso_bit%0d: got %b expected %b", j, MISO, exp_bits[8-j]);
            else pass_cnt++;
        end
        end_frame();
        tx_valid = 1'b0;
    endtask

    task automatic test_abort();
        int nv, fe, mh, cnt;
        logic [9:0] got;
        @(negedge clk);
        SS_n = 1'b0; MOSI = 1'b1;
        repeat (6) @(negedge clk);
        SS_n = 1'b1;
        cnt = 0;
        repeat (12) begin @(negedge clk); if (rx_valid === 1'b1) cnt++; end
        total_cnt++; if (cnt != 0) $display("FAIL abort_no_valid: got %0d expected 0", cnt); else pass_cnt++;
        do_frame(10'h1FF, nv, fe, got, mh);
        total_cnt++; if (got !== 10'h1FF || nv != 1 || fe != 11) $display("FAIL abort_next_frame: got %h x%0d @%0d expected 1ff x1 @11", got, nv, fe); else pass_cnt++;
        end_frame();
    endtask

    task automatic test_timeout();
        int nv, fe, mh, cnt;
        logic [9:0] got;
        do_frame(10'h2AA, nv, fe, got, mh);
        end_frame();
        tx_valid = 1'b0;
        do_frame(10'h300, nv, fe, got, mh);
        total_cnt++; if (got !== 10'h300) $display("FAIL tmo_frame: got %h expected 300", got); else pass_cnt++;
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
        cnt = 0;
        for (int w = 1; w <= 16; w++) begin
            @(negedge clk);
            if (w < 16 && err_timeout !== 1'b0) cnt++;
        end
        total_cnt++; if (cnt != 0) $display("FAIL tmo_early: got %0d early flags expected 0", cnt); else pass_cnt++;
        total_cnt++; if (err_timeout !== 1'b1) $display("FAIL tmo_edge16: got %b expected 1", err_timeout); else pass_cnt++;
        tx_data = 8'hFF; tx_valid = 1'b1;
        cnt = 0;
        repeat (10) begin @(negedge clk); if (MISO !== 1'b0) cnt++; end
        total_cnt++; if (cnt != 0) $display("FAIL tmo_miso_held: got %0d highs expected 0", cnt); else pass_cnt++;
        end_frame();
        tx_valid = 1'b0;
        total_cnt++; if (err_timeout !== 1'b1) $display("FAIL tmo_sticky: got %b expected 1", err_timeout); else pass_cnt++;
        SS_n = 1'b0;
        @(negedge clk);
        total_cnt++; if (err_timeout !== 1'b0) $display("FAIL tmo_clear: got %b expected 0", err_timeout); else pass_cnt++;
        end_frame();
`else
        cnt = 0;
        repeat (20) begin @(negedge clk); if (err_timeout !== 1'b0 || MISO !== 1'b0) cnt++; end
        total_cnt++; if (cnt != 0) $display("FAIL no_tmo_wait: got %0d bad cycles expected 0", cnt); else pass_cnt++;
        tx_data = 8'h81; tx_valid = 1'b1;
        @(negedge clk);
        total_cnt++; if (MISO !== 1'b1) $display("FAIL late_tx_valid: got %b expected 1", MISO); else pass_cnt++;
        end_frame();
        tx_valid = 1'b0;
`endif
    endtask

    initial begin
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_stale_tx_valid();
        test_abort();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
